// File: rtl/mem_write_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_if
// Purpose  : Buffers a frame of 16-bit pixels and writes it to DDR as a
//            sequence of data bursts, each followed by one write command.
// Revision : 1.0 - initial release
// ============================================================================
module mem_write_if #(
  parameter int BURST_LEN       = 512,
  parameter int BURST_LEN_BYTES = 1024,
  parameter int FIFO_DEPTH      = 2048
) (
  input  logic        clk,
  input  logic        reset_clk,
  input  logic        frame_start,
  input  logic [29:0] frame_base_addr,
  input  logic [23:0] frame_bytes,
  input  logic        frame_abort,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        mem_wr_full,
  output logic        mem_wr_en,
  output logic [15:0] mem_wr_data,
  output logic        mem_cmd_wr,
  output logic [29:0] mem_cmd_byte_addr,
  output logic [9:0]  mem_cmd_bl,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_FILL = 3'd1;
  localparam logic [2:0] c_DATA = 3'd2;
  localparam logic [2:0] c_CMD  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [c_AW-1:0] c_PTR_LAST    = c_AW'(FIFO_DEPTH - 1);
  localparam logic [c_CW-1:0] c_FULL_CNT    = c_CW'(FIFO_DEPTH);
  localparam logic [23:0]     c_BURST_WORDS = 24'(BURST_LEN);
  localparam logic [9:0]      c_BURST_BL    = 10'(BURST_LEN);
  localparam logic [29:0]     c_BURST_STEP  = 30'(BURST_LEN_BYTES);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [29:0]     r_addr;
  logic [23:0]     r_rem_words;
  logic [23:0]     r_frame_words;
  logic [23:0]     r_seen;
  logic [9:0]      r_wcnt;
  logic            r_overflow;
  logic            r_frame_done;

  logic            w_idle;
  logic            w_start;
  logic            w_fifo_full;
  logic            w_in_frame;
  logic            w_push;
  logic            w_drop;
  logic            w_last_word;
  logic [23:0]     w_start_words;
  logic [9:0]      w_burst;
  logic [23:0]     w_rem_after;
  logic [29:0]     w_step;

  assign w_idle        = (r_state == c_IDLE);
  assign w_start       = w_idle && frame_start && !frame_abort;
  assign w_start_words = frame_bytes >> 1;
  assign w_fifo_full   = (r_count == c_FULL_CNT);
  assign w_burst       = (r_rem_words >= c_BURST_WORDS) ? c_BURST_BL : r_rem_words[9:0];
  assign w_rem_after   = r_rem_words - 24'(w_burst);
  assign w_step        = (w_burst == c_BURST_BL) ? c_BURST_STEP : {19'd0, w_burst, 1'b0};

  // Words past the frame length are swallowed silently; only genuine
  // frame words that meet a full buffer count as an overflow.
  assign w_in_frame  = !w_idle && pix_valid && (r_seen < r_frame_words);
  assign w_push      = w_in_frame && !w_fifo_full;
  assign w_drop      = w_in_frame && w_fifo_full;
  assign w_last_word = mem_wr_en && (r_wcnt == (w_burst - 10'd1));

  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (frame_abort) begin
      w_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (frame_start) begin
            w_next = (w_start_words == 24'd0) ? c_DONE : c_FILL;
          end
        end
        c_FILL: begin
          if (24'(r_count) >= 24'(w_burst)) begin
            w_next = c_DATA;
          end
        end
        c_DATA: begin
          if (w_last_word) begin
            w_next = c_CMD;
          end
        end
        c_CMD:   w_next = (w_rem_after != 24'd0) ? c_FILL : c_DONE;
        c_DONE:  w_next = c_IDLE;
        default: w_next = c_IDLE;
      endcase
    end
  end

  // Abort gates the strobes in the same cycle so an abandoned burst never
  // reaches the memory controller.
  always_comb begin
    busy       = !w_idle;
    mem_wr_en  = (r_state == c_DATA) && !mem_wr_full && !frame_abort && (r_wcnt < w_burst);
    mem_cmd_wr = (r_state == c_CMD) && !frame_abort;
    mem_wr_data = mem_wr_en ? r_mem[r_rd_ptr] : 16'd0;
  end

  assign mem_cmd_byte_addr = r_addr;
  assign mem_cmd_bl        = w_burst;
  assign frame_done        = r_frame_done;
  assign overflow          = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_seen        <= '0;
      r_addr        <= '0;
      r_rem_words   <= '0;
      r_frame_words <= '0;
      r_wcnt        <= '0;
      r_overflow    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_idle) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_seen   <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
        end
        if (mem_wr_en) begin
          r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
        end
        case ({w_push, mem_wr_en})
          2'b10:   r_count <= r_count + c_CW'(1);
          2'b01:   r_count <= r_count - c_CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_in_frame) begin
          r_seen <= r_seen + 24'd1;
        end
      end

      if (w_start) begin
        r_addr        <= frame_base_addr;
        r_rem_words   <= w_start_words;
        r_frame_words <= w_start_words;
      end else if (mem_cmd_wr) begin
        r_addr      <= r_addr + w_step;
        r_rem_words <= w_rem_after;
      end

      if (w_start) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (r_state != c_DATA) begin
        r_wcnt <= '0;
      end else if (mem_wr_en) begin
        r_wcnt <= r_wcnt + 10'd1;
      end

      r_frame_done <= (r_state == c_DONE) && !frame_abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_if
// Purpose  : Directed self-checking bench for mem_write_if.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write_if;

  logic        clk = 1'b0;
  logic        reset_clk;
  logic        frame_start;
  logic [29:0] frame_base_addr;
  logic [23:0] frame_bytes;
  logic        frame_abort;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        mem_wr_full;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic        mem_cmd_wr;
  logic [29:0] mem_cmd_byte_addr;
  logic [9:0]  mem_cmd_bl;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  mem_write_if dut (
    .clk               (clk),
    .reset_clk         (reset_clk),
    .frame_start       (frame_start),
    .frame_base_addr   (frame_base_addr),
    .frame_bytes       (frame_bytes),
    .frame_abort       (frame_abort),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .mem_wr_full       (mem_wr_full),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data),
    .mem_cmd_wr        (mem_cmd_wr),
    .mem_cmd_byte_addr (mem_cmd_byte_addr),
    .mem_cmd_bl        (mem_cmd_bl),
    .busy              (busy),
    .frame_done        (frame_done),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] wr_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [9:0]  cmd_bl_q[$];
  int          cmd_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          toggle_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the memory-side traffic half a cycle after each active edge.
  always @(negedge clk) begin
    if (mem_wr_en) wr_q.push_back(mem_wr_data);
    if (mem_cmd_wr) begin
      cmd_addr_q.push_back(mem_cmd_byte_addr);
      cmd_bl_q.push_back(mem_cmd_bl);
      cmd_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) mem_wr_full = ~mem_wr_full;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    cmd_addr_q.delete();
    cmd_bl_q.delete();
    cmd_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_frame(input logic [29:0] a, input logic [23:0] b);
    frame_base_addr = a;
    frame_bytes     = b;
    frame_start     = 1'b1;
    tick();
    frame_start     = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [15:0] seed);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = seed + 16'(i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_cnt >= target) break;
      tick();
    end
    if (done_cnt >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset_clk = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b frame_done=%b overflow=%b, required 0 0 0", busy, frame_done, overflow);
    end
    n_checks++;
    if (mem_wr_en !== 1'b0 || mem_cmd_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: mem_wr_en=%b mem_cmd_wr=%b, required 0 0", mem_wr_en, mem_cmd_wr);
    end
    n_checks++;
    if (mem_wr_data !== 16'd0 || mem_cmd_byte_addr !== 30'd0 || mem_cmd_bl !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_buses: data=%h addr=%h bl=%0d, required 0 0 0", mem_wr_data, mem_cmd_byte_addr, mem_cmd_bl);
    end
    reset_clk = 1'b0;
    tick();
  endtask

  task automatic test_two_bursts();
    bit ok;
    int errs;
    clear_mon();
    start_frame(30'h0000_1000, 24'd2048);
    send_pixels(1024, 16'h0100);
    wait_done(1, 2000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL two_bursts_timeout: frame_done count %0d, required 1", done_cnt);
    end
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h0100 + 16'(i)) errs++;
    n_checks++;
    if (wr_q.size() != 1024 || errs != 0) begin
      n_fail++;
      $display("FAIL two_bursts_data: %0d words with %0d out of order, required 1024 with 0", wr_q.size(), errs);
    end
    n_checks++;
    if (cmd_addr_q.size() != 2 || cmd_addr_q[0] !== 30'h0000_1000 || cmd_addr_q[1] !== 30'h0000_1400 ||
        cmd_bl_q[0] !== 10'd512 || cmd_bl_q[1] !== 10'd512) begin
      n_fail++;
      $display("FAIL two_bursts_cmds: %0d commands seen, required 2 at 0x1000/0x1400 bl=512", cmd_addr_q.size());
    end
    tick();
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL two_bursts_end: done=%0d busy=%b overflow=%b, required 1 0 0", done_cnt, busy, overflow);
    end
  endtask

  task automatic test_partial_burst();
    bit ok;
    int errs;
    clear_mon();
    start_frame(30'h3FFF_FC00, 24'd1100);
    send_pixels(550, 16'h2000);
    wait_done(1, 1500, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL partial_timeout: frame_done count %0d, required 1", done_cnt);
    end
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h2000 + 16'(i)) errs++;
    n_checks++;
    if (wr_q.size() != 550 || errs != 0) begin
      n_fail++;
      $display("FAIL partial_data: %0d words with %0d out of order, required 550 with 0", wr_q.size(), errs);
    end
    // Second command wraps past the top of the 30-bit space.
    n_checks++;
    if (cmd_addr_q.size() != 2 || cmd_addr_q[0] !== 30'h3FFF_FC00 || cmd_addr_q[1] !== 30'h0000_0000 ||
        cmd_bl_q[0] !== 10'd512 || cmd_bl_q[1] !== 10'd38) begin
      n_fail++;
      $display("FAIL partial_cmds: %0d commands seen, required 2 at 0x3FFFFC00/0x0 bl=512/38", cmd_addr_q.size());
    end
    n_checks++;
    if (cmd_cyc_q.size() != 2 || done_cyc <= cmd_cyc_q[1]) begin
      n_fail++;
      $display("FAIL partial_done_order: frame_done at cycle %0d, required after second command", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs;
    clear_mon();
    mem_wr_full = 1'b0;
    toggle_en   = 1'b1;
    start_frame(30'h0000_8000, 24'd1024);
    send_pixels(512, 16'h3000);
    wait_done(1, 2000, ok);
    toggle_en   = 1'b0;
    mem_wr_full = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL backpressure_timeout: frame_done count %0d, required 1", done_cnt);
    end
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h3000 + 16'(i)) errs++;
    n_checks++;
    if (wr_q.size() != 512 || errs != 0) begin
      n_fail++;
      $display("FAIL backpressure_data: %0d words with %0d out of order, required 512 with 0", wr_q.size(), errs);
    end
    n_checks++;
    if (cmd_addr_q.size() != 1 || cmd_addr_q[0] !== 30'h0000_8000 || cmd_bl_q[0] !== 10'd512) begin
      n_fail++;
      $display("FAIL backpressure_cmd: %0d commands seen, required 1 at 0x8000 bl=512", cmd_addr_q.size());
    end
  endtask

  task automatic test_excess_words();
    bit ok;
    int errs;
    clear_mon();
    start_frame(30'h0000_0040, 24'd8);
    for (int i = 0; i < 10; i++) begin
      pix_valid   = 1'b1;
      pix_data    = 16'h7000 + 16'(i);
      frame_start = (i == 2);
      if (i == 2) begin
        frame_base_addr = 30'h2AAA_AAAA;
        frame_bytes     = 24'd100;
      end
      tick();
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    wait_done(1, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL excess_timeout: frame_done count %0d, required 1", done_cnt);
    end
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h7000 + 16'(i)) errs++;
    n_checks++;
    if (wr_q.size() != 4 || errs != 0) begin
      n_fail++;
      $display("FAIL excess_data: %0d words with %0d out of order, required 4 with 0", wr_q.size(), errs);
    end
    n_checks++;
    if (cmd_addr_q.size() != 1 || cmd_addr_q[0] !== 30'h0000_0040 || cmd_bl_q[0] !== 10'd4) begin
      n_fail++;
      $display("FAIL excess_cmd: %0d commands seen, required 1 at 0x40 bl=4", cmd_addr_q.size());
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL excess_overflow: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int errs;
    clear_mon();
    mem_wr_full = 1'b1;
    start_frame(30'h0001_0000, 24'd8192);
    send_pixels(2049, 16'h4000);
    n_checks++;
    if (overflow !== 1'b1 || wr_q.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: overflow=%b writes=%0d busy=%b, required 1 0 1", overflow, wr_q.size(), busy);
    end
    mem_wr_full = 1'b0;
    for (int i = 0; i < 3000 && wr_q.size() < 2048; i++) tick();
    for (int i = 0; i < 20; i++) tick();
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h4000 + 16'(i)) errs++;
    n_checks++;
    if (wr_q.size() != 2048 || errs != 0) begin
      n_fail++;
      $display("FAIL overflow_data: %0d words with %0d out of order, required 2048 with 0", wr_q.size(), errs);
    end
    n_checks++;
    if (cmd_addr_q.size() != 4 || cmd_addr_q[0] !== 30'h0001_0000 || cmd_addr_q[3] !== 30'h0001_0C00) begin
      n_fail++;
      $display("FAIL overflow_cmds: %0d commands seen, required 4 from 0x10000 to 0x10C00", cmd_addr_q.size());
    end
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || overflow !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL overflow_abort: busy=%b overflow=%b done=%0d, required 0 1 0", busy, overflow, done_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int errs;
    clear_mon();
    start_frame(30'h0050_0000, 24'd2048);
    for (int i = 0; i < 2000 && wr_q.size() < 100; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'h5000 + 16'(i);
      tick();
    end
    n_checks++;
    if (wr_q.size() < 100) begin
      n_fail++;
      $display("FAIL abort_reach_data: %0d words written, required at least 100", wr_q.size());
    end
    pix_valid   = 1'b0;
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b, required 0", busy);
    end
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (cmd_addr_q.size() != 0 || done_cnt != 0 || wr_q.size() >= 512) begin
      n_fail++;
      $display("FAIL abort_quiet: cmds=%0d done=%0d writes=%0d, required 0 0 <512", cmd_addr_q.size(), done_cnt, wr_q.size());
    end
    clear_mon();
    start_frame(30'h0060_0000, 24'd64);
    send_pixels(32, 16'h6000);
    wait_done(1, 100, ok);
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i] !== 16'h6000 + 16'(i)) errs++;
    n_checks++;
    if (!ok || wr_q.size() != 32 || errs != 0) begin
      n_fail++;
      $display("FAIL abort_next_frame: done=%0d words=%0d bad=%0d, required 1 32 0", done_cnt, wr_q.size(), errs);
    end
    n_checks++;
    if (cmd_addr_q.size() != 1 || cmd_addr_q[0] !== 30'h0060_0000 || cmd_bl_q[0] !== 10'd32) begin
      n_fail++;
      $display("FAIL abort_next_cmd: %0d commands seen, required 1 at 0x600000 bl=32", cmd_addr_q.size());
    end
  endtask

  task automatic test_zero_bytes();
    int s;
    clear_mon();
    frame_base_addr = 30'h0000_2000;
    frame_bytes     = 24'd0;
    frame_start     = 1'b1;
    s = cyc;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (done_cnt != 1 || done_cyc - s != 2) begin
      n_fail++;
      $display("FAIL zero_done: count=%0d delay=%0d, required 1 and 2", done_cnt, done_cyc - s);
    end
    n_checks++;
    if (wr_q.size() != 0 || cmd_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_traffic: writes=%0d cmds=%0d, required 0 0", wr_q.size(), cmd_addr_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int sz;
    clear_mon();
    start_frame(30'h0070_0000, 24'd2048);
    for (int i = 0; i < 2000 && wr_q.size() < 50; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'h8000 + 16'(i);
      tick();
    end
    reset_clk = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0 || wr_q.size() < 50) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b mem_wr_en=%b writes=%0d, required 0 0 >=50", busy, mem_wr_en, wr_q.size());
    end
    pix_valid = 1'b0;
    tick();
    tick();
    reset_clk = 1'b0;
    sz = wr_q.size();
    for (int i = 0; i < 40; i++) tick();
    n_checks++;
    if (wr_q.size() != sz || cmd_addr_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: extra writes=%0d cmds=%0d done=%0d busy=%b, required 0 0 0 0",
               wr_q.size() - sz, cmd_addr_q.size(), done_cnt, busy);
    end
  endtask

  initial begin
    reset_clk       = 1'b1;
    frame_start     = 1'b0;
    frame_base_addr = 30'd0;
    frame_bytes     = 24'd0;
    frame_abort     = 1'b0;
    pix_valid       = 1'b0;
    pix_data        = 16'd0;
    mem_wr_full     = 1'b0;
    test_reset();
    test_two_bursts();
    test_partial_burst();
    test_backpressure();
    test_excess_words();
    test_overflow();
    test_abort();
    test_zero_bytes();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
